// File: rtl/fp16_pkg.sv
// Shared fp16 definitions: field widths, bias, special encodings and divider FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  localparam logic [15:0] ZERO       = 16'h0000;
  localparam logic [14:0] MAX_FINITE = 15'h7BFF;
  localparam logic [14:0] DIV0       = 15'h7C00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fp16_mant_div.sv
// Iterative restoring mantissa divider: one quotient bit per step, MSB first.
// Latency: NQ steps after load; done pulses combinationally during the final step.
// Backpressure: none; the caller gates step.
module fp16_mant_div #(
  parameter int NQ = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [10:0]   ma,
  input  logic [10:0]   mb,
  output logic          done,
  output logic [NQ-1:0] q,
  output logic [11:0]   rem
);

  logic [11:0]   rem_q, rem_d;
  logic [10:0]   mb_q, mb_d;
  logic [NQ-1:0] q_q, q_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ge;
  logic [11:0]   diff;

  // Compare/subtract/shift for one quotient bit; remainder stays below 2*mb so 12 bits suffice
  always_comb begin
    rem_d = rem_q;
    mb_d  = mb_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    ge    = (rem_q >= {1'b0, mb_q});
    diff  = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    if (load) begin
      rem_d = {1'b0, ma};
      mb_d  = mb;
      q_d   = '0;
      cnt_d = '0;
    end else if (step) begin
      rem_d = {diff[10:0], 1'b0};
      q_d   = {q_q[NQ-2:0], ge};
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Core state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      mb_q  <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      mb_q  <= mb_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = step && (cnt_q == 4'(NQ - 1));
  assign q    = q_q;
  assign rem  = rem_q;

endmodule

// File: rtl/fp16_div_seq.sv
// Sequential fp16 divider (out = a / b), truncating; FP16_DIV_ROUND_EN selects round-to-nearest-even.
// Latency: 14 cycles normal (15 with FP16_DIV_ROUND_EN), 1 cycle for zero/div-by-zero specials.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module fp16_div_seq #(
  parameter int EXP_BIAS = fp16_pkg::EXP_BIAS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out,
  output logic        div_by_zero
);
  import fp16_pkg::*;

`ifdef FP16_DIV_ROUND_EN
  localparam int NQ = 13;
`else
  localparam int NQ = 12;
`endif

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        sign_q, sign_d;
  logic        dz_q, dz_d;
  logic [6:0]  exp_q, exp_d;
  logic [15:0] out_q, out_d;

  logic          core_load, core_step, core_done;
  logic [NQ-1:0] quo;
  logic [11:0]   rem;
  logic [10:0]   ma, mb;

  logic signed [7:0] ef;
  logic [9:0]        man;
  logic [15:0]       norm_res;
`ifdef FP16_DIV_ROUND_EN
  logic [10:0]       man_r;
  logic              guard, sticky;
`else
  logic              unused_rem;
  assign unused_rem = ^rem;
`endif

  assign ma = {1'b1, a[9:0]};
  assign mb = {1'b1, b[9:0]};

  fp16_mant_div #(.NQ(NQ)) u_mant_div (
    .clk  (clk),
    .rst  (rst),
    .load (core_load),
    .step (core_step),
    .ma   (ma),
    .mb   (mb),
    .done (core_done),
    .q    (quo),
    .rem  (rem)
  );

  // Normalise the quotient, optionally round, then saturate or flush on exponent range
  always_comb begin
    ef = $signed({exp_q[6], exp_q});
    if (quo[NQ-1]) begin
      man = quo[NQ-2:NQ-11];
`ifdef FP16_DIV_ROUND_EN
      guard  = quo[NQ-12];
      sticky = quo[0] | (rem != 12'd0);
`endif
    end else begin
      man = quo[NQ-3:NQ-12];
      ef  = ef - 8'sd1;
`ifdef FP16_DIV_ROUND_EN
      guard  = quo[0];
      sticky = (rem != 12'd0);
`endif
    end
`ifdef FP16_DIV_ROUND_EN
    man_r = {1'b0, man} + {10'd0, guard & (sticky | man[0])};
    man   = man_r[9:0];
    if (man_r[10]) ef = ef + 8'sd1;
`endif
    if (ef >= $signed(8'(EXP_MAX)))  norm_res = {sign_q, MAX_FINITE};
    else if (ef <= 8'sd0)            norm_res = ZERO;
    else                             norm_res = {sign_q, ef[4:0], man};
  end

  // Next-state logic: handshake, special-case resolution at accept, and sequencing of the core
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sign_d      = sign_q;
    dz_d        = dz_q;
    exp_d       = exp_q;
    out_d       = out_q;
    core_load   = 1'b0;
    core_step   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d     = a[15] ^ b[15];
          exp_d      = {2'b00, a[14:10]} - {2'b00, b[14:10]} + 7'(EXP_BIAS);
          in_ready_d = 1'b0;
          if (b[14:10] == 5'd0) begin
            out_d       = {a[15] ^ b[15], DIV0};
            dz_d        = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (a[14:10] == 5'd0) begin
            out_d       = ZERO;
            dz_d        = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            core_load = 1'b1;
            state_d   = DIV;
          end
        end
      end
      DIV: begin
        core_step = 1'b1;
        if (core_done) state_d = NORM;
      end
      NORM: begin
        out_d       = norm_res;
        dz_d        = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      dz_q        <= 1'b0;
      exp_q       <= '0;
      out_q       <= ZERO;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      dz_q        <= dz_d;
      exp_q       <= exp_d;
      out_q       <= out_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out         = out_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed bench for fp16_div_seq: arithmetic vectors, specials, range, backpressure, mid-op reset.
// Honours FP16_DIV_ROUND_EN for the rounded expectations and latency.
// Outputs are sampled 1 time unit after each rising edge.
module tb_fp16_div_seq;

`ifdef FP16_DIV_ROUND_EN
  localparam int          LAT_N   = 15;
  localparam logic [15:0] EXP_5_3 = 16'h3EAB;
`else
  localparam int          LAT_N   = 14;
  localparam logic [15:0] EXP_5_3 = 16'h3EAA;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  fp16_div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, measure latency, check the result, then drain it.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic [15:0] eout, input logic edz, input int elat);
    int lat;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, elat);
    check({tag, ".out"}, {16'd0, out}, {16'd0, eout});
    check({tag, ".dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drain_vld"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int highs;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.in_ready",  {31'd0, in_ready},    32'd1);
    check("rst.out_valid", {31'd0, out_valid},   32'd0);
    check("rst.out",       {16'd0, out},         32'd0);
    check("rst.dz",        {31'd0, div_by_zero}, 32'd0);

    run_op("div6_2",   16'h4600, 16'h4000, 16'h4200, 1'b0, LAT_N);
    run_op("div5_3",   16'h4500, 16'h4200, EXP_5_3,  1'b0, LAT_N);
    run_op("divm6_2",  16'hC600, 16'h4000, 16'hC200, 1'b0, LAT_N);
    run_op("zero_a",   16'h0000, 16'h4000, 16'h0000, 1'b0, 1);
    run_op("sat",      16'h7800, 16'h1400, 16'h7BFF, 1'b0, LAT_N);
    run_op("flush",    16'h0400, 16'h7800, 16'h0000, 1'b0, LAT_N);
    run_op("zero_0",   16'h0000, 16'h0000, 16'h7C00, 1'b1, 1);
    run_op("negdz",    16'hC000, 16'h0000, 16'hFC00, 1'b1, 1);

    // Backpressure: hold the result, poke in_valid with a special that would overwrite it
    a = 16'h4600; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp.vld", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      a = 16'h0000; b = 16'h0000; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp.hold_out", {16'd0, out}, 32'h4200);
      check("bp.hold_rdy", {31'd0, in_ready}, 32'd0);
      check("bp.hold_vld", {31'd0, out_valid}, 32'd1);
      check("bp.hold_dz",  {31'd0, div_by_zero}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.rel_rdy", {31'd0, in_ready},  32'd1);
    check("bp.rel_vld", {31'd0, out_valid}, 32'd0);
    check("bp.rel_out", {16'd0, out},       32'h4200);
    run_op("bp.next", 16'hC600, 16'h4000, 16'hC200, 1'b0, LAT_N);

    // Load a div-by-zero result so the reset check sees real changes
    run_op("pre_rst", 16'hC000, 16'h0000, 16'hFC00, 1'b1, 1);
    a = 16'h4600; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst.in_ready",  {31'd0, in_ready},    32'd1);
    check("mrst.out_valid", {31'd0, out_valid},   32'd0);
    check("mrst.out",       {16'd0, out},         32'd0);
    check("mrst.dz",        {31'd0, div_by_zero}, 32'd0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) highs++;
    end
    check("mrst.no_vld", highs, 0);
    run_op("mrst.after", 16'h4600, 16'h4000, 16'h4200, 1'b0, LAT_N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
